jtag_shift_engine: RTL and testbench



---
 rtl/jtag_shift_engine.sv | 151 +++++++++++++++
 tb/tb_jtag_shift_engine.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_shift_engine.sv
// JTAG probe engine: shifts up to MAX_BITS TMS/TDI bits per command with a programmable
// TCK divider and returns the TDO bits captured during the shift.
module jtag_shift_engine #(
  parameter int MAX_BITS = 32,
  parameter int DIV_W    = 8,
  parameter int LEN_W    = $clog2(MAX_BITS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                cmd_trst,
  input  logic [MAX_BITS-1:0] cmd_tms,
  input  logic [MAX_BITS-1:0] cmd_tdi,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [MAX_BITS-1:0] rsp_tdo,
  output logic                busy,
  output logic                tck,
  output logic                tms,
  output logic                tdi,
  output logic                trstn,
  input  logic                tdo
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_e;

  state_e              state_q;
  logic                cmd_ready_q;
  logic                rsp_valid_q;
  logic [MAX_BITS-1:0] rsp_tdo_q;
  logic                tck_q, tms_q, tdi_q, trstn_q;
  logic [DIV_W-1:0]    div_q, cnt_q;
  logic [LEN_W-1:0]    len_q, idx_q;
  logic                trst_q;
  logic [MAX_BITS-1:0] tms_sh_q, tdi_sh_q, shadow_q, mask_q;

  logic [LEN_W-1:0]    len_d;
  logic [LEN_W-1:0]    idx_d;
  logic                half_done_d;

  always_comb begin
    len_d       = (cmd_len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : cmd_len;
    idx_d       = idx_q + LEN_W'(1);
    half_done_d = (cnt_q == div_q);
  end

  // NOTE: every register here is state, so all updates use non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_tdo_q   <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      trstn_q     <= 1'b1;
      div_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      trst_q      <= 1'b0;
      tms_sh_q    <= '0;
      tdi_sh_q    <= '0;
      shadow_q    <= '0;
      mask_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            div_q       <= cfg_div;
            len_q       <= len_d;
            idx_q       <= '0;
            cnt_q       <= '0;
            trst_q      <= cmd_trst;
            tms_sh_q    <= cmd_tms >> 1;
            tdi_sh_q    <= cmd_tdi >> 1;
            shadow_q    <= '0;
            mask_q      <= MAX_BITS'(1);
            if (len_d == '0) begin
              state_q <= DONE;
            end else begin
              state_q <= LOW;
              tms_q   <= cmd_trst ? 1'b1 : cmd_tms[0];
              tdi_q   <= cmd_trst ? 1'b0 : cmd_tdi[0];
              trstn_q <= ~cmd_trst;
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        LOW: begin
          if (half_done_d) begin
            cnt_q   <= '0;
            tck_q   <= 1'b1;
            state_q <= HIGH;
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end
        HIGH: begin
          if (half_done_d) begin
            cnt_q  <= '0;
            tck_q  <= 1'b0;
            idx_q  <= idx_d;
            mask_q <= mask_q << 1;
            // TDO is taken at the falling edge, i.e. while it still reflects this bit.
            if (!trst_q && tdo) shadow_q <= shadow_q | mask_q;
            if (idx_d == len_q) begin
              state_q <= DONE;
              trstn_q <= 1'b1;
            end else begin
              state_q  <= LOW;
              tms_q    <= trst_q ? 1'b1 : tms_sh_q[0];
              tdi_q    <= trst_q ? 1'b0 : tdi_sh_q[0];
              tms_sh_q <= tms_sh_q >> 1;
              tdi_sh_q <= tdi_sh_q >> 1;
            end
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end
        DONE: begin
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
            rsp_tdo_q   <= shadow_q;
          end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_tdo   = rsp_tdo_q;
  assign busy      = (state_q != IDLE);
  assign tck       = tck_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;
  assign trstn     = trstn_q;

endmodule

// File: tb/tb_jtag_shift_engine.sv
// Scoreboard bench for jtag_shift_engine with a TDI->TDO loopback register standing in for the TAP.
module tb_jtag_shift_engine;

  localparam int MAX_BITS = 32;
  localparam int DIV_W    = 8;
  localparam int LEN_W    = $clog2(MAX_BITS + 1);

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [DIV_W-1:0]    cfg_div = '0;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic [LEN_W-1:0]    cmd_len = '0;
  logic                cmd_trst = 1'b0;
  logic [MAX_BITS-1:0] cmd_tms = '0;
  logic [MAX_BITS-1:0] cmd_tdi = '0;
  logic                rsp_valid;
  logic                rsp_ready = 1'b0;
  logic [MAX_BITS-1:0] rsp_tdo;
  logic                busy, tck, tms, tdi, trstn, tdo;

  jtag_shift_engine #(.MAX_BITS(MAX_BITS), .DIV_W(DIV_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .cfg_div(cfg_div),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_trst(cmd_trst), .cmd_tms(cmd_tms), .cmd_tdi(cmd_tdi),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tdo(rsp_tdo),
    .busy(busy), .tck(tck), .tms(tms), .tdi(tdi), .trstn(trstn), .tdo(tdo)
  );

  always #5 clk = ~clk;

  // Loopback TAP: TDI taken on the rising TCK edge, presented on TDO from the falling edge.
  logic tdi_s, lb;
  logic lb_clr = 1'b0;
  always @(posedge tck) tdi_s <= tdi;
  always @(negedge tck or posedge lb_clr)
    if (lb_clr) lb <= 1'b0;
    else        lb <= tdi_s;
  assign tdo = lb;

  int   pulse_cnt = 0;
  logic tms_log [0:1023];
  always @(posedge tck) begin
    tms_log[pulse_cnt % 1024] <= tms;
    pulse_cnt <= pulse_cnt + 1;
  end

  typedef struct {
    logic [MAX_BITS-1:0] tdo;
    logic [MAX_BITS-1:0] tms;
    int lat;
    int n;
    int d;
    bit trst;
    int base;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic issue(input int len, input bit trst, input logic [MAX_BITS-1:0] tms_v,
                       input logic [MAX_BITS-1:0] tdi_v, input int div, input int div_after);
    exp_t e;
    int   n;
    int   w = 0;
    while (cmd_ready !== 1'b1 && w < 100) begin @(posedge clk); #1; w++; end
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL issue_ready: cmd_ready=%b required 1", cmd_ready);
    end
    lb_clr = 1'b1; #1; lb_clr = 1'b0;
    n      = (len > MAX_BITS) ? MAX_BITS : len;
    e.n    = n;
    e.d    = div;
    e.trst = trst;
    e.lat  = 2 * n * (div + 1) + 1;
    e.base = pulse_cnt;
    e.tdo  = '0;
    e.tms  = '0;
    for (int i = 0; i < n; i++) begin
      e.tms[i] = trst ? 1'b1 : tms_v[i];
      if (!trst && i > 0) e.tdo[i] = tdi_v[i-1];
    end
    sb.push_back(e);
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(len);
    cmd_trst  = trst;
    cmd_tms   = tms_v;
    cmd_tdi   = tdi_v;
    cfg_div   = DIV_W'(div);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cfg_div   = DIV_W'(div_after);
  endtask

  task automatic collect(input string name, input int hold);
    exp_t e;
    int   k = 0, hi = 0, trst_lo = 0;
    logic [MAX_BITS-1:0] got_tms;
    logic [MAX_BITS-1:0] held;
    bit   stable = 1'b1;
    e = sb.pop_front();
    while (rsp_valid !== 1'b1 && k < 5000) begin
      if (tck === 1'b1) hi++;
      if (trstn === 1'b0) trst_lo++;
      @(posedge clk); #1; k++;
    end
    n_vec++;
    if (k != e.lat) begin n_err++; $display("FAIL %s_latency: got %0d cycles, required %0d", name, k, e.lat); end
    n_vec++;
    if (pulse_cnt - e.base != e.n) begin
      n_err++; $display("FAIL %s_pulses: got %0d, required %0d", name, pulse_cnt - e.base, e.n);
    end
    n_vec++;
    if (hi != e.n * (e.d + 1)) begin
      n_err++; $display("FAIL %s_tck_high: got %0d cycles, required %0d", name, hi, e.n * (e.d + 1));
    end
    n_vec++;
    if (trst_lo != (e.trst ? 2 * e.n * (e.d + 1) : 0)) begin
      n_err++; $display("FAIL %s_trstn_low: got %0d cycles, required %0d", name, trst_lo,
                        e.trst ? 2 * e.n * (e.d + 1) : 0);
    end
    got_tms = '0;
    for (int i = 0; i < e.n; i++) got_tms[i] = tms_log[(e.base + i) % 1024];
    n_vec++;
    if (got_tms !== e.tms) begin n_err++; $display("FAIL %s_tms: got %h, required %h", name, got_tms, e.tms); end
    n_vec++;
    if (rsp_tdo !== e.tdo) begin n_err++; $display("FAIL %s_tdo: got %h, required %h", name, rsp_tdo, e.tdo); end
    held = rsp_tdo;
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_tdo !== held || cmd_ready !== 1'b0 || tck !== 1'b0 || busy !== 1'b1)
        stable = 1'b0;
    end
    if (hold > 0) begin
      n_vec++;
      if (!stable) begin n_err++; $display("FAIL %s_stall: outputs moved during %0d-cycle stall, required stable", name, hold); end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_vec++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      n_err++; $display("FAIL %s_handshake: rsp_valid,cmd_ready=%b required 01", name, {rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_in_rst: got %b required 0", cmd_ready); end
    rst = 1'b0;
    n_vec++;
    if ({tck, tms, tdi, trstn, rsp_valid, busy, rsp_tdo} !== {6'b010100, {MAX_BITS{1'b0}}}) begin
      n_err++; $display("FAIL reset_pins: tck,tms,tdi,trstn,rsp_valid,busy=%b required 010100", {tck, tms, tdi, trstn, rsp_valid, busy});
    end
    @(posedge clk); #1;
    n_vec++;
    if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_after: got %b required 1", cmd_ready); end
  endtask

  task automatic test_loopback();
    issue(8, 1'b0, 32'h80, 32'hA5, 0, 0);
    collect("loopback", 0);
  endtask

  task automatic test_divider();
    issue(5, 1'b0, 32'h1F, $urandom, 3, 0);
    collect("divider", 0);
  endtask

  task automatic test_trst_and_clamps();
    issue(4, 1'b1, 32'h0, 32'hF, 3, 3);
    collect("trst", 0);
    issue(0, 1'b0, $urandom, $urandom, 0, 0);
    collect("len0", 0);
    issue(0, 1'b0, $urandom, $urandom, 5, 5);
    collect("len0_div5", 0);
    issue(40, 1'b0, $urandom, $urandom, 0, 0);
    collect("clamp40", 0);
  endtask

  task automatic test_backpressure();
    issue(6, 1'b0, $urandom, $urandom, 1, 1);
    collect("backpressure", 20);
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 4; t++) begin
      issue($urandom_range(1, MAX_BITS), 1'b0, $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 7));
      collect("b2b", 0);
    end
  endtask

  task automatic test_reset_mid();
    int  base;
    int  w = 0;
    bit  saw_valid = 1'b0;
    base = pulse_cnt;
    issue(16, 1'b0, $urandom, $urandom, 0, 0);
    void'(sb.pop_back());  // abandoned command yields no response
    while (pulse_cnt - base < 4 && w < 200) begin @(posedge clk); #1; w++; end
    rst = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({tck, tms, tdi, trstn, busy, rsp_valid, cmd_ready} !== 7'b0101000) begin
      n_err++; $display("FAIL midrst_pins: tck,tms,tdi,trstn,busy,rsp_valid,cmd_ready=%b required 0101000",
                        {tck, tms, tdi, trstn, busy, rsp_valid, cmd_ready});
    end
    rst = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0) saw_valid = 1'b1;
    end
    n_vec++;
    if (saw_valid) begin n_err++; $display("FAIL midrst_no_rsp: rsp_valid seen after abandoned command, required none"); end
    issue(4, 1'b0, 32'h9, 32'hD, 0, 0);
    collect("after_midrst", 0);
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_divider();
    test_trst_and_clamps();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
